// File: rtl/io_out_arbiter_pkg.sv
// Shared definitions for the processor output arbiter and the input-side arbiters built on it.
// Holds the width helpers, the default geometry and the tagged word record.
package io_out_arbiter_pkg;

  localparam int DEF_NUBITS = 16;
  localparam int DEF_NPROCS = 4;
  localparam int DEF_NUIOOU = 2;

  // A one-entry address space still needs a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_width(input int nuioou);
    return clog2_min1(nuioou);
  endfunction

  function automatic int src_width(input int nprocs);
    return clog2_min1(nprocs);
  endfunction

  typedef struct packed {
    logic [DEF_NUBITS-1:0]                 data;
    logic [addr_width(DEF_NUIOOU)-1:0]     addr;
    logic [src_width(DEF_NPROCS)-1:0]      src;
  } io_word_t;

endpackage

// File: rtl/io_out_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after i_ptr,
// wrapping modulo N, plus a found flag.
module io_out_arbiter_rr_pick
  import io_out_arbiter_pkg::*;
#(
  parameter int N  = DEF_NPROCS,
  parameter int SW = src_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_grant,
  output logic          o_found
);

  // Scan offsets from farthest to nearest so the nearest match is the last assignment.
  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant = SW'((int'(i_ptr) + k) % N);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_out_arbiter.sv
// Buffers one non-stallable write per processor and drains them round-robin onto a
// valid/ready sink, tagging each word with its source and flagging dropped words.
module io_out_arbiter
  import io_out_arbiter_pkg::*;
#(
  parameter  int NUBITS = DEF_NUBITS,
  parameter  int NPROCS = DEF_NPROCS,
  parameter  int NUIOOU = DEF_NUIOOU,
  localparam int AW     = addr_width(NUIOOU),
  localparam int SW     = src_width(NPROCS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPROCS-1:0]        out_en,
  input  logic [NPROCS*NUBITS-1:0] io_out,
  input  logic [NPROCS*AW-1:0]     addr_out,
  input  logic [NPROCS-1:0]        ovf_clr,
  output logic [NUBITS-1:0]        sink_data,
  output logic [AW-1:0]            sink_addr,
  output logic [SW-1:0]            sink_src,
  output logic                     sink_valid,
  input  logic                     sink_ready,
  output logic [NPROCS-1:0]        pend,
  output logic [NPROCS-1:0]        ovf
);

  logic [NUBITS-1:0] w_hold_data [NPROCS];
  logic [AW-1:0]     w_hold_addr [NPROCS];
  logic [NPROCS-1:0] w_pend;
  logic [NPROCS-1:0] w_ovf;
  logic [NPROCS-1:0] w_xfer;
  logic [SW-1:0]     w_gidx;
  logic              w_found;
  logic              w_free;
  logic              w_grant;

  logic [SW-1:0]     r_ptr;
  logic [NUBITS-1:0] r_sink_data;
  logic [AW-1:0]     r_sink_addr;
  logic [SW-1:0]     r_sink_src;
  logic              r_sink_valid;

  assign w_free  = !r_sink_valid || sink_ready;
  assign w_grant = w_free && w_found;

  io_out_arbiter_rr_pick #(
    .N  (NPROCS),
    .SW (SW)
  ) u_pick (
    .i_req   (w_pend),
    .i_ptr   (r_ptr),
    .o_grant (w_gidx),
    .o_found (w_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NPROCS; gi++) begin : g_hold
      logic [NUBITS-1:0] r_data;
      logic [AW-1:0]     r_addr;
      logic              r_pend;
      logic              r_ovf;
      logic              w_cap;
      logic              w_drop;

      assign w_xfer[gi] = w_grant && (w_gidx == SW'(gi));
      // A slot emptying into the output register this edge can take the new word.
      assign w_cap  = out_en[gi] && (!r_pend || w_xfer[gi]);
      assign w_drop = out_en[gi] && r_pend && !w_xfer[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_data <= '0;
          r_addr <= '0;
          r_pend <= 1'b0;
          r_ovf  <= 1'b0;
        end else begin
          if (w_cap) begin
            r_data <= io_out[gi*NUBITS +: NUBITS];
            r_addr <= addr_out[gi*AW +: AW];
            r_pend <= 1'b1;
          end else if (w_xfer[gi]) begin
            r_pend <= 1'b0;
          end
          if (w_drop) begin
            r_ovf <= 1'b1;
          end else if (ovf_clr[gi]) begin
            r_ovf <= 1'b0;
          end
        end
      end

      assign w_hold_data[gi] = r_data;
      assign w_hold_addr[gi] = r_addr;
      assign w_pend[gi]      = r_pend;
      assign w_ovf[gi]       = r_ovf;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_sink_data  <= '0;
      r_sink_addr  <= '0;
      r_sink_src   <= '0;
      r_sink_valid <= 1'b0;
    end else if (w_free) begin
      if (w_found) begin
        r_sink_data  <= w_hold_data[w_gidx];
        r_sink_addr  <= w_hold_addr[w_gidx];
        r_sink_src   <= w_gidx;
        r_sink_valid <= 1'b1;
        r_ptr        <= (w_gidx == SW'(NPROCS - 1)) ? '0 : w_gidx + SW'(1);
      end else begin
        r_sink_valid <= 1'b0;
      end
    end
  end

  assign sink_data  = r_sink_data;
  assign sink_addr  = r_sink_addr;
  assign sink_src   = r_sink_src;
  assign sink_valid = r_sink_valid;
  assign pend       = w_pend;
  assign ovf        = w_ovf;

endmodule

// File: tb/tb_io_out_arbiter.sv
// Directed self-checking bench for io_out_arbiter with the default geometry
// (4 processors, 16-bit data, 1-bit address, 2-bit source index).
module tb_io_out_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  out_en;
  logic [63:0] io_out;
  logic [3:0]  addr_out;
  logic [3:0]  ovf_clr;
  logic [15:0] sink_data;
  logic [0:0]  sink_addr;
  logic [1:0]  sink_src;
  logic        sink_valid;
  logic        sink_ready;
  logic [3:0]  pend;
  logic [3:0]  ovf;

  int tests  = 0;
  int failed = 0;

  io_out_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .out_en     (out_en),
    .io_out     (io_out),
    .addr_out   (addr_out),
    .ovf_clr    (ovf_clr),
    .sink_data  (sink_data),
    .sink_addr  (sink_addr),
    .sink_src   (sink_src),
    .sink_valid (sink_valid),
    .sink_ready (sink_ready),
    .pend       (pend),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst === 1'b1 && sink_valid === 1'b1 && sink_ready === 1'b1)
      $display("[TB] xfer src=%0d addr=%0d data=%h", sink_src, sink_addr, sink_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int p, input logic [15:0] d, input logic a);
    io_out[p*16 +: 16] = d;
    addr_out[p]        = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    out_en = '0;
    ovf_clr = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_en = '0; io_out = '0; addr_out = '0; ovf_clr = '0; sink_ready = 1'b0;
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_addr, sink_data} !== 20'h0) begin
      failed++;
      $display("FAIL reset_sink: got %h expected %h", {sink_valid, sink_src, sink_addr, sink_data}, 20'h0);
    end
    tests++;
    if ({pend, ovf} !== 8'h00) begin
      failed++;
      $display("FAIL reset_flags: got %h expected %h", {pend, ovf}, 8'h00);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (sink_valid !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle: got %b expected 0", sink_valid);
    end
  endtask

  task automatic test_single();
    sink_ready = 1'b1;
    set_word(0, 16'h1234, 1'b1);
    out_en = 4'b0001;
    tick();
    out_en = '0;
    tests++;
    if ({pend, sink_valid} !== {4'b0001, 1'b0}) begin
      failed++;
      $display("FAIL single_cycle1: got pend=%b valid=%b expected pend=0001 valid=0", pend, sink_valid);
    end
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'd0, 1'b1, 16'h1234}) begin
      failed++;
      $display("FAIL single_cycle2: got %h expected %h", {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'd0, 1'b1, 16'h1234});
    end
    tick();
    tests++;
    if ({sink_valid, pend, ovf} !== 9'h0) begin
      failed++;
      $display("FAIL single_cycle3: got valid=%b pend=%b ovf=%b expected all 0", sink_valid, pend, ovf);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] base;
    do_reset();
    sink_ready = 1'b1;
    for (int burst = 0; burst < 2; burst++) begin
      base = (burst == 0) ? 16'd10 : 16'd50;
      for (int p = 0; p < 4; p++) set_word(p, base + 16'(p * 10), 1'(p));
      out_en = 4'b1111;
      tick();
      out_en = '0;
      tests++;
      if ({pend, sink_valid} !== {4'b1111, 1'b0}) begin
        failed++;
        $display("FAIL rr_capture%0d: got pend=%b valid=%b expected pend=1111 valid=0", burst, pend, sink_valid);
      end
      for (int k = 0; k < 4; k++) begin
        tick();
        tests++;
        if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'(k), 1'(k), base + 16'(k * 10)}) begin
          failed++;
          $display("FAIL rr_order%0d_%0d: got %h expected %h", burst, k,
                   {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'(k), 1'(k), base + 16'(k * 10)});
        end
      end
    end
    tick();
    tests++;
    if ({sink_valid, pend} !== 5'h0) begin
      failed++;
      $display("FAIL rr_drain: got valid=%b pend=%b expected 0", sink_valid, pend);
    end
  endtask

  task automatic test_backpressure();
    sink_ready = 1'b0;
    set_word(0, 16'hAAAA, 1'b0);
    out_en = 4'b0001;
    tick();
    out_en = '0;
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_data} !== {1'b1, 2'd0, 16'hAAAA}) begin
      failed++;
      $display("FAIL bp_grant: got %h expected %h", {sink_valid, sink_src, sink_data}, {1'b1, 2'd0, 16'hAAAA});
    end
    set_word(2, 16'h1111, 1'b1);
    out_en = 4'b0100;
    tick();
    out_en = '0;
    tests++;
    if ({pend, ovf} !== {4'b0100, 4'b0000}) begin
      failed++;
      $display("FAIL bp_first_held: got pend=%b ovf=%b expected pend=0100 ovf=0000", pend, ovf);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'd0, 1'b0, 16'hAAAA}) begin
        failed++;
        $display("FAIL bp_stable%0d: got %h expected %h", c, {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'd0, 1'b0, 16'hAAAA});
      end
    end
    set_word(2, 16'h2222, 1'b0);
    out_en = 4'b0100;
    tick();
    out_en = '0;
    tests++;
    if ({pend, ovf, sink_data} !== {4'b0100, 4'b0100, 16'hAAAA}) begin
      failed++;
      $display("FAIL bp_drop: got pend=%b ovf=%b data=%h expected pend=0100 ovf=0100 data=aaaa", pend, ovf, sink_data);
    end
    sink_ready = 1'b1;
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'd2, 1'b1, 16'h1111}) begin
      failed++;
      $display("FAIL bp_release: got %h expected %h", {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'd2, 1'b1, 16'h1111});
    end
    tick();
    tests++;
    if ({sink_valid, pend, ovf} !== {1'b0, 4'b0000, 4'b0100}) begin
      failed++;
      $display("FAIL bp_after: got valid=%b pend=%b ovf=%b expected valid=0 pend=0000 ovf=0100", sink_valid, pend, ovf);
    end
  endtask

  task automatic test_ovf_clr_race();
    sink_ready = 1'b0;
    set_word(2, 16'h3333, 1'b0);
    out_en = 4'b0100;
    tick();
    out_en = '0;
    tick();
    set_word(2, 16'h4444, 1'b1);
    out_en = 4'b0100;
    tick();
    set_word(2, 16'h5555, 1'b0);
    out_en = 4'b0100;
    ovf_clr = 4'b0100;
    tick();
    out_en = '0;
    tests++;
    if (ovf !== 4'b0100) begin
      failed++;
      $display("FAIL race_set_wins: got ovf=%b expected 0100", ovf);
    end
    tick();
    ovf_clr = '0;
    tests++;
    if ({ovf, pend, sink_src, sink_data} !== {4'b0000, 4'b0100, 2'd2, 16'h3333}) begin
      failed++;
      $display("FAIL race_lone_clr: got ovf=%b pend=%b src=%0d data=%h expected ovf=0000 pend=0100 src=2 data=3333",
               ovf, pend, sink_src, sink_data);
    end
    sink_ready = 1'b1;
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'd2, 1'b1, 16'h4444}) begin
      failed++;
      $display("FAIL race_held_word: got %h expected %h", {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'd2, 1'b1, 16'h4444});
    end
    tick();
    tests++;
    if (sink_valid !== 1'b0) begin
      failed++;
      $display("FAIL race_idle: got %b expected 0", sink_valid);
    end
  endtask

  task automatic test_back_to_back();
    sink_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_word(1, 16'(c + 1), 1'(c));
      out_en = 4'b0010;
      tick();
      if (c >= 1) begin
        tests++;
        if ({sink_valid, sink_src, sink_addr, sink_data} !== {1'b1, 2'd1, 1'(c - 1), 16'(c)}) begin
          failed++;
          $display("FAIL stream_%0d: got %h expected %h", c, {sink_valid, sink_src, sink_addr, sink_data}, {1'b1, 2'd1, 1'(c - 1), 16'(c)});
        end
      end
    end
    out_en = '0;
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_data} !== {1'b1, 2'd1, 16'd8}) begin
      failed++;
      $display("FAIL stream_last: got %h expected %h", {sink_valid, sink_src, sink_data}, {1'b1, 2'd1, 16'd8});
    end
    tick();
    tests++;
    if ({sink_valid, pend, ovf} !== 9'h0) begin
      failed++;
      $display("FAIL stream_end: got valid=%b pend=%b ovf=%b expected all 0", sink_valid, pend, ovf);
    end
  endtask

  task automatic test_reset_mid();
    sink_ready = 1'b0;
    set_word(0, 16'h0007, 1'b0);
    out_en = 4'b0001;
    tick();
    out_en = '0;
    tick();
    set_word(1, 16'h0008, 1'b0);
    set_word(2, 16'h0009, 1'b1);
    out_en = 4'b0110;
    tick();
    set_word(1, 16'h000A, 1'b1);
    out_en = 4'b0010;
    tick();
    out_en = '0;
    tests++;
    if ({sink_valid, pend, ovf} !== {1'b1, 4'b0110, 4'b0010}) begin
      failed++;
      $display("FAIL mid_before: got valid=%b pend=%b ovf=%b expected valid=1 pend=0110 ovf=0010", sink_valid, pend, ovf);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({sink_valid, pend, ovf, sink_src, sink_data} !== 27'h0) begin
      failed++;
      $display("FAIL mid_async: got valid=%b pend=%b ovf=%b src=%0d data=%h expected all 0",
               sink_valid, pend, ovf, sink_src, sink_data);
    end
    rst = 1'b1;
    sink_ready = 1'b1;
    set_word(0, 16'h00B0, 1'b0);
    set_word(3, 16'h00B3, 1'b1);
    out_en = 4'b1001;
    tick();
    out_en = '0;
    tests++;
    if (pend !== 4'b1001) begin
      failed++;
      $display("FAIL mid_recapture: got pend=%b expected 1001", pend);
    end
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_data} !== {1'b1, 2'd0, 16'h00B0}) begin
      failed++;
      $display("FAIL mid_first_grant: got %h expected %h", {sink_valid, sink_src, sink_data}, {1'b1, 2'd0, 16'h00B0});
    end
    tick();
    tests++;
    if ({sink_valid, sink_src, sink_data} !== {1'b1, 2'd3, 16'h00B3}) begin
      failed++;
      $display("FAIL mid_second_grant: got %h expected %h", {sink_valid, sink_src, sink_data}, {1'b1, 2'd3, 16'h00B3});
    end
    tick();
    tests++;
    if (sink_valid !== 1'b0) begin
      failed++;
      $display("FAIL mid_idle: got %b expected 0", sink_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ovf_clr_race();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/io_out_arbiter.md
Name: io_out_arbiter

Overview:
- Shares one output sink (DAC, serial link or host FIFO) between NPROCS proc_fx instances.
- Each processor's out_en is a one-cycle, non-stallable write pulse carrying io_out and addr_out.
- The block buffers one word per processor and arbitrates round-robin onto a valid/ready sink interface.
- It tags each word with its source index and flags lost words.

Parameters:
- NUBITS, 16, data word width (matches proc_fx NUBITS).
- NPROCS, 4, number of processors sharing the sink; at least 2.
- NUIOOU, 2, output addresses per processor; AW = $clog2(NUIOOU), minimum 1.
- SW, $clog2(NPROCS), source-index width (derived, internal).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- out_en  in  NPROCS  per-processor write strobe; bit i from processor i.
- io_out  in  NPROCS*NUBITS  packed data; processor i occupies bits [i*NUBITS +: NUBITS].
- addr_out  in  NPROCS*AW  packed port address; processor i occupies [i*AW +: AW].
- ovf_clr  in  NPROCS  per-processor one-cycle clear of the sticky overflow flag.
- sink_data  out  NUBITS  granted word.
- sink_addr  out  AW  granted word's addr_out.
- sink_src  out  SW  index of the processor that produced the word.
- sink_valid  out  1  output register holds a word.
- sink_ready  in  1  sink accepts the word on this edge when sink_valid=1.
- pend  out  NPROCS  holding register i is occupied.
- ovf  out  NPROCS  sticky flag: a word from processor i was dropped.

Behaviour:
Reset (rst=0, asynchronous):
- All holding registers are emptied; pend=0.
- sink_valid=0; sink_data, sink_addr and sink_src are 0.
- ovf=0 and the round-robin pointer ptr=0.
- Words in flight are lost with no flag.

Holding stage (per processor i):
- On an edge with out_en[i]=1, io_out and addr_out are captured into hold i and pend[i] is set.
- Capture is allowed if hold i is empty, or if hold i is being transferred to the output register on that same edge.
- Otherwise the new word is dropped, the held word is kept, and ovf[i] is set.
- ovf[i] clears on ovf_clr[i]=1. If a set and a clear occur on the same edge, set wins.

Output stage:
- The output register is free when sink_valid=0, or when sink_valid=1 and sink_ready=1.
- When the register is free and some pend bit is 1, the grant goes to the first set pend bit searching from ptr upward, wrapping modulo NPROCS.
- On a grant to index g:
  - The held word loads into sink_data and sink_addr; sink_src=g; sink_valid=1.
  - pend[g] clears unless refilled on the same edge.
  - ptr becomes (g+1) mod NPROCS.
- When the register is free and no pend bit is set, sink_valid drops to 0 on that edge.
- While sink_valid=1 and sink_ready=0, sink_data, sink_addr and sink_src stay stable and no grant occurs.

Timing and fairness:
- Latency: out_en high in cycle 0 gives pend=1 in cycle 1 and sink_valid=1 in cycle 2, assuming the stage is free and no contention.
- Throughput: one word per cycle with sink_ready held at 1.
- Fairness: a continuously pending requester waits at most NPROCS-1 grants.

Boundary cases:
- Simultaneous out_en on every bit: all are captured, then drained in order ptr, ptr+1, …
- Back-to-back out_en pulses from one processor while sink_ready=1 with no other traffic: no drop, because capture-on-transfer applies.
- sink_ready asserted while sink_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - the AW/SW width derivation functions (clog2 with minimum 1);
  - a packed record for data, address and source, reused by future input-side arbiters.
- One natural sub-module, rr_pick: combinational round-robin priority picker taking a request vector and ptr, returning a grant index and a "found" bit. Reused later for the req_in/io_in arbiter.

Test Plan:
1. Reset release, single pulse: NPROCS=4, sink_ready=1; out_en=0001, io_out[0]=16'h1234, addr=1 in cycle 0 → cycle 2 shows sink_valid=1, sink_data=16'h1234, sink_addr=1, sink_src=0; sink_valid=0 in cycle 3; ovf=0.
2. Round-robin order: out_en=1111 in one cycle with data 10, 20, 30, 40, sink_ready=1 → sink_src sequence 0,1,2,3 on consecutive cycles with matching data; then out_en=1111 again → order restarts from ptr=0 (last grant was 3).
3. Backpressure: sink_ready=0 and one word granted; out_en[2] pulses twice, 3 cycles apart → sink outputs stable throughout; first pulse held; second dropped with ovf[2]=1; after sink_ready=1 both the output word and held word 1 deliver.
4. Overflow clear race: ovf_clr[2] and a new drop on the same edge → ovf[2] stays 1; a lone ovf_clr[2] → ovf[2]=0.
5. Streaming, capture-on-transfer: sink_ready=1, out_en[1] high 8 consecutive cycles with data 1..8 → sink_data 1..8 in order, no ovf.
6. Reset mid-operation: rst=0 while sink_valid=1 and pend=0110 → immediately sink_valid=0, pend=0, ovf=0; after release, the first grant starts from index 0.
